pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the in-order core. Successor to the fixed IF/ID/EX hold/flush logic.
- Generalised to NSTAGE stages, NRDR prioritised redirect sources, a multi-cycle load-use sequencer with configurable extra bubbles, and a registered redirect handshake toward the PC generator.
- Sits beside the pipeline registers and drives per-stage hold and flush.

Parameters:
- NSTAGE, 5, pipeline stage count; stage 0 = IF, index grows toward writeback.
- NRDR, 2, redirect source count; index 0 has highest priority (0 = trap/clint, 1 = branch mispredict).
- PC_W, 32, PC width.
- RDR_STAGE, 2, stage where redirects resolve (EX); stages 0..RDR_STAGE-1 are flushed.
- LU_HOLD_STAGE, 1, highest stage held during load-use (ID); must be < RDR_STAGE.
- LU_EXTRA, 0, extra bubble cycles after load data returns (0..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- hold_req_i  in  NSTAGE  per-stage stall request (multdiv, clint, LSU, ...).
- rdr_valid_i  in  NRDR  redirect requests.
- rdr_pc_i  in  NRDR*PC_W  packed targets; source k occupies bits [k*PC_W +: PC_W].
- lu_req_i  in  1  load-use hazard detected in ID.
- lsu_done_i  in  1  outstanding load data available.
- redirect_ready_i  in  1  PC generator accepts redirect.
- hold_o  out  NSTAGE  stage j keeps its input register.
- flush_o  out  NSTAGE  stage j clears its input register (inserts bubble).
- redirect_valid_o  out  1  redirect presented to the PC generator.
- redirect_pc_o  out  PC_W  redirect target.
- lu_busy_o  out  1  load-use sequencer not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Sequencer goes to IDLE, bubble counter 0, pending flag 0, pending PC 0.
  - All outputs are forced to 0 while rst_n is low.
- Hold vector:
  - req = hold_req_i | lu_mask | (pend ? 1 : 0).
  - lu_mask sets bits 0..LU_HOLD_STAGE when the sequencer is in WAIT_LOAD or BUBBLE.
  - hold_o[j] = OR of req[NSTAGE-1:j]. A stall in stage k freezes every younger stage.
- Bubble insertion: flush_o[j] = 1 when hold_o[j-1]=1 and hold_o[j]=0 (j≥1).
- Redirect acceptance:
  - A redirect is accepted when any rdr_valid_i bit is set and hold_o[RDR_STAGE]=0.
  - The lowest set index wins. Requests are ignored while RDR_STAGE is held; the source re-asserts them.
- On an accepted redirect:
  - flush_o[0..RDR_STAGE-1]=1 and hold_o[0..RDR_STAGE-1]=0; flush overrides hold.
  - The load-use sequencer returns to IDLE next edge, and lu_mask is suppressed in the same cycle.
- Redirect handshake:
  - The accepted redirect drives redirect_valid_o=1 and redirect_pc_o=target combinationally, with zero latency.
  - If redirect_ready_i=0, the target is latched into the pending register (pend=1).
  - While pend=1: redirect_valid_o=1, redirect_pc_o=pending PC, flush_o[0]=1 each cycle. pend clears on the edge where redirect_ready_i=1.
  - A new accepted redirect while pending overwrites the pending PC. Its new target is output in the same cycle.
- Load-use sequencer:
  - IDLE: lu_req_i=1 and hold_o[LU_HOLD_STAGE+1]=0 → WAIT_LOAD; lu_req_i is ignored otherwise.
  - WAIT_LOAD: mask active; lsu_done_i=1 → IDLE if LU_EXTRA=0, else BUBBLE with cnt=LU_EXTRA.
  - BUBBLE: mask active; cnt decrements each cycle; cnt=1 → IDLE.
  - Accepted redirect → IDLE from any state, with priority over lsu_done_i.
- lu_busy_o = (state != IDLE).
- Simultaneous events:
  - Trap and mispredict in the same cycle: the trap target is used.
  - lu_req_i and an accepted redirect in the same cycle: the redirect wins and the sequencer stays IDLE.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, adds three 32-bit saturating counters, cleared on reset:
  - stall_cnt: cycles with hold_o[0]=1.
  - flush_cnt: accepted redirects.
  - lu_cnt: WAIT_LOAD entries.
- Exported as perf_stall_o, perf_flush_o, perf_lu_o.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- hold_req_i=5'b00100 for 3 cycles → hold_o=5'b00111 and flush_o=5'b01000 each cycle; both return to 0 after release.
- rdr_valid_i=2'b11, targets 0x8000_0100 and 0x8000_0200, redirect_ready_i=1 → redirect_pc_o=0x8000_0100 and flush_o=5'b00011 in the same cycle.
- Redirect 0x8000_0040 with redirect_ready_i=0 for 2 cycles → redirect_valid_o stays 1 with 0x8000_0040 and flush_o[0]=1 for 3 cycles; pend clears after ready.
- lu_req_i pulse, lsu_done_i after 4 cycles, LU_EXTRA=2 → hold_o[1:0]=2'b11 and flush_o[2]=1 for 4+2 cycles, then lu_busy_o=0.
- Mispredict redirect while in WAIT_LOAD → lu_busy_o=0 next cycle and flush_o[1:0]=2'b11 that cycle.
- rst_n dropped mid-BUBBLE and mid-pending → all outputs 0 immediately; after release, state IDLE and redirect_valid_o=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage hold/flush generation for an NSTAGE in-order
// pipeline. It covers prioritised redirects with a pending handshake toward
// the PC generator, and a load-use sequencer that can add extra bubbles.
// Optional build macro: PIPE_HAZARD_PERF_EN adds stall/flush/load-use
// saturating performance counters.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   hold_req_i         per-stage stall requests
//   rdr_valid_i/pc_i   redirect requests, index 0 has highest priority
//   lu_req_i           load-use hazard detected in ID
//   lsu_done_i         load data returned
//   redirect_ready_i   PC generator accepts the redirect
//   hold_o, flush_o    per-stage hold / bubble insert
//   redirect_valid_o   redirect presented to the PC generator
//   redirect_pc_o      redirect target
//   lu_busy_o          load-use sequencer active
//   perf_*_o           performance counters (PIPE_HAZARD_PERF_EN only)
module pipe_hazard_ctrl #(
   parameter int unsigned NSTAGE        = 5,
   parameter int unsigned NRDR          = 2,
   parameter int unsigned PC_W          = 32,
   parameter int unsigned RDR_STAGE     = 2,
   parameter int unsigned LU_HOLD_STAGE = 1,
   parameter int unsigned LU_EXTRA      = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NSTAGE-1:0]    hold_req_i,
   input  logic [NRDR-1:0]      rdr_valid_i,
   input  logic [NRDR*PC_W-1:0] rdr_pc_i,
   input  logic                 lu_req_i,
   input  logic                 lsu_done_i,
   input  logic                 redirect_ready_i,
   output logic [NSTAGE-1:0]    hold_o,
   output logic [NSTAGE-1:0]    flush_o,
   output logic                 redirect_valid_o,
   output logic [PC_W-1:0]      redirect_pc_o,
   output logic                 lu_busy_o
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0]          perf_stall_o,
   output logic [31:0]          perf_flush_o,
   output logic [31:0]          perf_lu_o
`endif
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_LOAD, ST_BUBBLE} lu_state_e;

   lu_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic [PC_W-1:0]   pend_pc_q, pend_pc_d;

   logic              hold_hi;
   logic              rdr_acc;
   logic              rdr_found;
   logic [PC_W-1:0]   rdr_pc_sel;
   logic              lu_mask_en;
   logic [NSTAGE-1:0] req;
   logic [NSTAGE-1:0] hold_raw;
   logic [NSTAGE-1:0] hold_c;
   logic [NSTAGE-1:0] flush_c;

   // Hold/flush vectors and redirect arbitration
   always_comb begin
      // Acceptance depends only on stages >= RDR_STAGE, which the load-use
      // mask and the pending bit never touch, so no combinational loop.
      hold_hi = 1'b0;
      for (int unsigned j = RDR_STAGE; j < NSTAGE; j++) hold_hi = hold_hi | hold_req_i[j];
      rdr_acc = (|rdr_valid_i) && !hold_hi;

      rdr_pc_sel = '0;
      rdr_found  = 1'b0;
      for (int unsigned k = 0; k < NRDR; k++) begin
         if (rdr_valid_i[k] && !rdr_found) begin
            rdr_pc_sel = rdr_pc_i[k*PC_W +: PC_W];
            rdr_found  = 1'b1;
         end
      end

      lu_mask_en = (state_q != ST_IDLE) && !rdr_acc;
      req = hold_req_i;
      if (lu_mask_en) begin
         for (int unsigned j = 0; j <= LU_HOLD_STAGE; j++) req[j] = 1'b1;
      end
      if (pend_q) req[0] = 1'b1;

      // A stall in stage j freezes every younger stage
      hold_raw[NSTAGE-1] = req[NSTAGE-1];
      for (int unsigned j = NSTAGE-1; j > 0; j--) hold_raw[j-1] = hold_raw[j] | req[j-1];

      hold_c = hold_raw;
      if (rdr_acc) begin
         for (int unsigned j = 0; j < RDR_STAGE; j++) hold_c[j] = 1'b0;
      end

      flush_c = '0;
      for (int unsigned j = 1; j < NSTAGE; j++) flush_c[j] = hold_c[j-1] & ~hold_c[j];
      if (pend_q) flush_c[0] = 1'b1;
      if (rdr_acc) begin
         for (int unsigned j = 0; j < RDR_STAGE; j++) flush_c[j] = 1'b1;
      end
   end

   // Load-use sequencer and pending-redirect next state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;

      if (rdr_acc) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (lu_req_i && !hold_raw[LU_HOLD_STAGE+1]) state_d = ST_WAIT_LOAD;
            end
            ST_WAIT_LOAD: begin
               if (lsu_done_i) begin
                  if (LU_EXTRA == 0) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_BUBBLE;
                     cnt_d   = CNT_W'(LU_EXTRA);
                  end
               end
            end
            ST_BUBBLE: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // A new redirect overwrites any pending target
      if (rdr_acc) begin
         pend_d    = !redirect_ready_i;
         pend_pc_d = rdr_pc_sel;
      end else if (pend_q && redirect_ready_i) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   // Outputs are combinational (zero-latency redirect) and forced low in reset
   assign hold_o           = rst_n ? hold_c : '0;
   assign flush_o          = rst_n ? flush_c : '0;
   assign redirect_valid_o = rst_n & (rdr_acc | pend_q);
   assign redirect_pc_o    = !rst_n ? '0 : (rdr_acc ? rdr_pc_sel : pend_pc_q);
   assign lu_busy_o        = rst_n & (state_q != ST_IDLE);

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic [31:0] lu_cnt_q, lu_cnt_d;

   // Saturating event counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      lu_cnt_d    = lu_cnt_q;
      if (hold_c[0] && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
      if (rdr_acc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
      if (state_q == ST_IDLE && state_d == ST_WAIT_LOAD && lu_cnt_q != '1)
         lu_cnt_d = lu_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         lu_cnt_q    <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         lu_cnt_q    <= lu_cnt_d;
      end
   end

   assign perf_stall_o = stall_cnt_q;
   assign perf_flush_o = flush_cnt_q;
   assign perf_lu_o    = lu_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (NSTAGE=5, NRDR=2, LU_EXTRA=2).
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  hold_req_i;
   logic [1:0]  rdr_valid_i;
   logic [63:0] rdr_pc_i;
   logic        lu_req_i;
   logic        lsu_done_i;
   logic        redirect_ready_i;
   logic [4:0]  hold_o;
   logic [4:0]  flush_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        lu_busy_o;

   int total = 0;
   int bad   = 0;

   pipe_hazard_ctrl #(
      .NSTAGE(5), .NRDR(2), .PC_W(32), .RDR_STAGE(2), .LU_HOLD_STAGE(1), .LU_EXTRA(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hold_req_i(hold_req_i), .rdr_valid_i(rdr_valid_i),
      .rdr_pc_i(rdr_pc_i), .lu_req_i(lu_req_i), .lsu_done_i(lsu_done_i),
      .redirect_ready_i(redirect_ready_i), .hold_o(hold_o), .flush_o(flush_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .lu_busy_o(lu_busy_o)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hold_req_i = '0; rdr_valid_i = '0; rdr_pc_i = '0;
      lu_req_i = 1'b0; lsu_done_i = 1'b0; redirect_ready_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      hold_req_i = 5'b00100; rdr_valid_i = 2'b01; rdr_pc_i = {32'h8000_0200, 32'h8000_0100};
      lu_req_i = 1'b1; lsu_done_i = 1'b0; redirect_ready_i = 1'b0;
      #3;
      total++; if (hold_o !== 5'b0) begin bad++; $display("FAIL rst_hold actual=%b required=%b", hold_o, 5'b0); end
      total++; if (flush_o !== 5'b0) begin bad++; $display("FAIL rst_flush actual=%b required=%b", flush_o, 5'b0); end
      total++; if (redirect_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid actual=%b required=0", redirect_valid_o); end
      total++; if (redirect_pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc actual=%h required=0", redirect_pc_o); end
      total++; if (lu_busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy actual=%b required=0", lu_busy_o); end
      idle_inputs();
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      total++; if (hold_o !== 5'b0 || flush_o !== 5'b0) begin bad++; $display("FAIL post_rst_vec hold=%b flush=%b required=0", hold_o, flush_o); end
      total++; if (redirect_valid_o !== 1'b0 || lu_busy_o !== 1'b0) begin bad++; $display("FAIL post_rst_ctl valid=%b busy=%b required=0", redirect_valid_o, lu_busy_o); end
   endtask

   task automatic test_hold();
      cyc();
      hold_req_i = 5'b00100;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (hold_o !== 5'b00111) begin bad++; $display("FAIL stall_hold[%0d] actual=%b required=%b", i, hold_o, 5'b00111); end
         total++; if (flush_o !== 5'b01000) begin bad++; $display("FAIL stall_flush[%0d] actual=%b required=%b", i, flush_o, 5'b01000); end
         cyc();
      end
      hold_req_i = 5'b0;
      #1;
      total++; if (hold_o !== 5'b0 || flush_o !== 5'b0) begin bad++; $display("FAIL stall_release hold=%b flush=%b required=0", hold_o, flush_o); end
      // Stall at the last stage holds everything, no bubble anywhere
      hold_req_i = 5'b10000;
      #1;
      total++; if (hold_o !== 5'b11111 || flush_o !== 5'b0) begin bad++; $display("FAIL stall_top hold=%b flush=%b required=11111/00000", hold_o, flush_o); end
      cyc();
      hold_req_i = 5'b0;
   endtask

   task automatic test_priority();
      cyc();
      rdr_valid_i = 2'b11; rdr_pc_i = {32'h8000_0200, 32'h8000_0100}; redirect_ready_i = 1'b1;
      #1;
      total++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0100) begin bad++; $display("FAIL prio_pc valid=%b pc=%h required=1/80000100", redirect_valid_o, redirect_pc_o); end
      total++; if (flush_o !== 5'b00011 || hold_o !== 5'b0) begin bad++; $display("FAIL prio_vec flush=%b hold=%b required=00011/00000", flush_o, hold_o); end
      cyc();
      rdr_valid_i = 2'b0;
      #1;
      total++; if (redirect_valid_o !== 1'b0 || flush_o !== 5'b0) begin bad++; $display("FAIL prio_after valid=%b flush=%b required=0", redirect_valid_o, flush_o); end
      // Redirect ignored while EX is held
      hold_req_i = 5'b00100; rdr_valid_i = 2'b10;
      #1;
      total++; if (redirect_valid_o !== 1'b0 || hold_o !== 5'b00111 || flush_o !== 5'b01000) begin bad++; $display("FAIL rdr_blocked valid=%b hold=%b flush=%b required=0/00111/01000", redirect_valid_o, hold_o, flush_o); end
      // Stall below the redirect stage is overridden by the flush
      hold_req_i = 5'b00010;
      #1;
      total++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0200) begin bad++; $display("FAIL rdr_low_stall valid=%b pc=%h required=1/80000200", redirect_valid_o, redirect_pc_o); end
      total++; if (hold_o !== 5'b0 || flush_o !== 5'b00011) begin bad++; $display("FAIL rdr_override hold=%b flush=%b required=00000/00011", hold_o, flush_o); end
      cyc();
      idle_inputs();
   endtask

   task automatic test_pending();
      cyc();
      rdr_valid_i = 2'b10; rdr_pc_i = {32'h8000_0040, 32'h0}; redirect_ready_i = 1'b0;
      #1;
      total++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0040 || flush_o !== 5'b00011) begin bad++; $display("FAIL pend_c0 valid=%b pc=%h flush=%b required=1/80000040/00011", redirect_valid_o, redirect_pc_o, flush_o); end
      for (int i = 1; i < 3; i++) begin
         cyc();
         rdr_valid_i = 2'b0; redirect_ready_i = (i == 2);
         #1;
         total++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0040) begin bad++; $display("FAIL pend_c%0d valid=%b pc=%h required=1/80000040", i, redirect_valid_o, redirect_pc_o); end
         total++; if (hold_o !== 5'b00001 || flush_o !== 5'b00011) begin bad++; $display("FAIL pend_vec%0d hold=%b flush=%b required=00001/00011", i, hold_o, flush_o); end
      end
      cyc();
      #1;
      total++; if (redirect_valid_o !== 1'b0 || flush_o !== 5'b0 || hold_o !== 5'b0) begin bad++; $display("FAIL pend_clear valid=%b flush=%b hold=%b required=0", redirect_valid_o, flush_o, hold_o); end
      // Overwrite a pending target with a new redirect
      redirect_ready_i = 1'b0; rdr_valid_i = 2'b10; rdr_pc_i = {32'h8000_0044, 32'h0};
      cyc();
      rdr_valid_i = 2'b01; rdr_pc_i = {32'h0, 32'h8000_0300};
      #1;
      total++; if (redirect_pc_o !== 32'h8000_0300) begin bad++; $display("FAIL pend_new_pc actual=%h required=80000300", redirect_pc_o); end
      cyc();
      rdr_valid_i = 2'b0;
      #1;
      total++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0300) begin bad++; $display("FAIL pend_overwrite valid=%b pc=%h required=1/80000300", redirect_valid_o, redirect_pc_o); end
      redirect_ready_i = 1'b1;
      cyc();
      idle_inputs();
   endtask

   task automatic test_load_use();
      cyc();
      lu_req_i = 1'b1;
      #1;
      total++; if (lu_busy_o !== 1'b0 || hold_o !== 5'b0) begin bad++; $display("FAIL lu_start busy=%b hold=%b required=0", lu_busy_o, hold_o); end
      cyc();
      lu_req_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         lsu_done_i = (i == 3);
         #1;
         total++; if (hold_o !== 5'b00011 || flush_o !== 5'b00100 || lu_busy_o !== 1'b1) begin bad++; $display("FAIL lu_seq[%0d] hold=%b flush=%b busy=%b required=00011/00100/1", i, hold_o, flush_o, lu_busy_o); end
         cyc();
      end
      lsu_done_i = 1'b0;
      #1;
      total++; if (lu_busy_o !== 1'b0 || hold_o !== 5'b0 || flush_o !== 5'b0) begin bad++; $display("FAIL lu_end busy=%b hold=%b flush=%b required=0", lu_busy_o, hold_o, flush_o); end
      // lu_req ignored while stage 2 is held
      hold_req_i = 5'b00100; lu_req_i = 1'b1;
      cyc();
      hold_req_i = 5'b0; lu_req_i = 1'b0;
      #1;
      total++; if (lu_busy_o !== 1'b0) begin bad++; $display("FAIL lu_blocked actual=%b required=0", lu_busy_o); end
      // lu_req together with an accepted redirect: redirect wins
      lu_req_i = 1'b1; rdr_valid_i = 2'b10; rdr_pc_i = {32'h8000_0080, 32'h0};
      cyc();
      idle_inputs();
      #1;
      total++; if (lu_busy_o !== 1'b0) begin bad++; $display("FAIL lu_vs_rdr actual=%b required=0", lu_busy_o); end
   endtask

   task automatic test_lu_redirect();
      cyc();
      lu_req_i = 1'b1;
      cyc();
      lu_req_i = 1'b0;
      #1;
      total++; if (lu_busy_o !== 1'b1) begin bad++; $display("FAIL lurdr_wait actual=%b required=1", lu_busy_o); end
      rdr_valid_i = 2'b10; rdr_pc_i = {32'h8000_00c0, 32'h0}; lsu_done_i = 1'b1;
      #1;
      total++; if (flush_o !== 5'b00011 || hold_o !== 5'b0) begin bad++; $display("FAIL lurdr_vec flush=%b hold=%b required=00011/00000", flush_o, hold_o); end
      cyc();
      idle_inputs();
      #1;
      total++; if (lu_busy_o !== 1'b0 || hold_o !== 5'b0) begin bad++; $display("FAIL lurdr_after busy=%b hold=%b required=0", lu_busy_o, hold_o); end
   endtask

   task automatic test_reset_mid();
      // Into BUBBLE, then drop reset
      cyc();
      lu_req_i = 1'b1;
      cyc();
      lu_req_i = 1'b0; lsu_done_i = 1'b1;
      cyc();
      lsu_done_i = 1'b0;
      #1;
      total++; if (lu_busy_o !== 1'b1 || hold_o !== 5'b00011) begin bad++; $display("FAIL rmid_bubble busy=%b hold=%b required=1/00011", lu_busy_o, hold_o); end
      rst_n = 1'b0;
      #1;
      total++; if (lu_busy_o !== 1'b0 || hold_o !== 5'b0 || flush_o !== 5'b0) begin bad++; $display("FAIL rmid_bub_rst busy=%b hold=%b flush=%b required=0", lu_busy_o, hold_o, flush_o); end
      cyc();
      rst_n = 1'b1;
      cyc();
      #1;
      total++; if (lu_busy_o !== 1'b0 || redirect_valid_o !== 1'b0 || hold_o !== 5'b0) begin bad++; $display("FAIL rmid_bub_rel busy=%b valid=%b hold=%b required=0", lu_busy_o, redirect_valid_o, hold_o); end
      // Pending redirect, then drop reset
      redirect_ready_i = 1'b0; rdr_valid_i = 2'b01; rdr_pc_i = {32'h0, 32'h8000_0500};
      cyc();
      rdr_valid_i = 2'b0;
      #1;
      total++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0500) begin bad++; $display("FAIL rmid_pend valid=%b pc=%h required=1/80000500", redirect_valid_o, redirect_pc_o); end
      rst_n = 1'b0;
      #1;
      total++; if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'h0 || flush_o !== 5'b0) begin bad++; $display("FAIL rmid_pend_rst valid=%b pc=%h flush=%b required=0", redirect_valid_o, redirect_pc_o, flush_o); end
      cyc();
      rst_n = 1'b1;
      cyc();
      #1;
      total++; if (redirect_valid_o !== 1'b0 || flush_o !== 5'b0 || hold_o !== 5'b0) begin bad++; $display("FAIL rmid_pend_rel valid=%b flush=%b hold=%b required=0", redirect_valid_o, flush_o, hold_o); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_hold();
      test_priority();
      test_pending();
      test_load_use();
      test_lu_redirect();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
